// File: rtl/pipelined_control_unit.sv
// Decode-to-EX control unit: one-cycle registered control word with load-use and multicycle M-op stalls.
// Backpressure: inReady drops for load-use hazards, flush and MULDIV_WAIT; bubbles are registered meanwhile.
module pipelined_control_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int MULDIV_LATENCY = 4,
    parameter bit ENABLE_M       = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [6:0]            opcode,
    input  logic [6:0]            funct7,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  outValid,
    output logic                  pcUpdate,
    output logic                  memoryReadEnable,
    output logic                  memoryWriteEnable,
    output logic                  registerWriteEnable,
    output logic                  pcAdderSrc,
    output logic                  writeBackFromAluOrMemory,
    output logic [1:0]            aluSrc1,
    output logic [1:0]            aluSrc2,
    output logic [2:0]            aluOperation,
    output logic                  mulDivEnable,
    output logic                  illegal,
    output logic [REG_ADDR_W-1:0] outRd,
    output logic                  busy
);
    typedef enum logic {RUN, MULDIV_WAIT} state_t;

    typedef struct packed {
        logic       pcUpdate;
        logic       memRd;
        logic       memWr;
        logic       regWr;
        logic       pcAdderSrc;
        logic       wbMem;
        logic [1:0] aluSrc1;
        logic [1:0] aluSrc2;
        logic [2:0] aluOp;
        logic       mulDiv;
        logic       illegal;
    } ctrlWord_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_LATENCY - 1);

    state_t                state;
    logic [3:0]            waitCnt;
    ctrlWord_t             word;
    ctrlWord_t             dec;
    logic                  loadUse;
    logic                  accept;

    always_comb begin
        dec = '0;
        case (opcode)
            OP_R: begin
                dec.regWr  = 1'b1;
                dec.aluOp  = 3'b010;
                dec.mulDiv = ENABLE_M && (funct7 == F7_MULDIV);
            end
            OP_I: begin
                dec.regWr   = 1'b1;
                dec.aluSrc2 = 2'b01;
                dec.aluOp   = 3'b011;
            end
            OP_LOAD: begin
                dec.regWr   = 1'b1;
                dec.memRd   = 1'b1;
                dec.wbMem   = 1'b1;
                dec.aluSrc2 = 2'b01;
            end
            OP_STORE: begin
                dec.memWr   = 1'b1;
                dec.aluSrc2 = 2'b01;
            end
            OP_BRANCH: begin
                dec.pcUpdate = 1'b1;
                dec.aluOp    = 3'b001;
            end
            OP_JAL: begin
                dec.pcUpdate = 1'b1;
                dec.regWr    = 1'b1;
                dec.aluSrc1  = 2'b01;
                dec.aluSrc2  = 2'b10;
                dec.aluOp    = 3'b100;
            end
            OP_JALR: begin
                dec.pcUpdate   = 1'b1;
                dec.regWr      = 1'b1;
                dec.aluSrc1    = 2'b01;
                dec.aluSrc2    = 2'b10;
                dec.aluOp      = 3'b101;
                dec.pcAdderSrc = 1'b1;
            end
            OP_LUI: begin
                dec.regWr   = 1'b1;
                dec.aluSrc1 = 2'b10;
                dec.aluSrc2 = 2'b01;
                dec.aluOp   = 3'b110;
            end
            OP_AUIPC: begin
                dec.regWr   = 1'b1;
                dec.aluSrc1 = 2'b01;
                dec.aluSrc2 = 2'b01;
                dec.aluOp   = 3'b111;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Hazard is judged against the word currently held in EX, i.e. the register outputs.
    assign loadUse = outValid && word.memRd && (outRd != '0) && inValid &&
                     ((outRd == rs1) || (outRd == rs2));
    assign inReady = (state == RUN) && !loadUse && !flush;
    assign accept  = inValid && inReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= RUN;
            waitCnt  <= '0;
            word     <= '0;
            outValid <= 1'b0;
            outRd    <= '0;
        end else if (flush) begin
            state    <= RUN;
            waitCnt  <= '0;
            word     <= '0;
            outValid <= 1'b0;
            outRd    <= '0;
        end else begin
            if (accept) begin
                word     <= dec;
                outValid <= 1'b1;
                outRd    <= rd;
                if (dec.mulDiv && (MULDIV_LATENCY > 1)) begin
                    state   <= MULDIV_WAIT;
                    waitCnt <= WAIT_LOAD;
                end
            end else begin
                word     <= '0;
                outValid <= 1'b0;
                outRd    <= '0;
            end
            // Leave the wait on the same edge the counter lands on zero.
            if (state == MULDIV_WAIT) begin
                waitCnt <= waitCnt - 4'd1;
                if (waitCnt <= 4'd1) begin
                    state <= RUN;
                end
            end
        end
    end

    assign pcUpdate                 = word.pcUpdate;
    assign memoryReadEnable         = word.memRd;
    assign memoryWriteEnable        = word.memWr;
    assign registerWriteEnable      = word.regWr;
    assign pcAdderSrc               = word.pcAdderSrc;
    assign writeBackFromAluOrMemory = word.wbMem;
    assign aluSrc1                  = word.aluSrc1;
    assign aluSrc2                  = word.aluSrc2;
    assign aluOperation             = word.aluOp;
    assign mulDivEnable             = word.mulDiv;
    assign illegal                  = word.illegal;
    assign busy                     = (state == MULDIV_WAIT);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios plus a randomized stream against a table/queue-free cycle model.
module tb_pipelined_control_unit;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       flush = 1'b0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [6:0] opcode = '0;
    logic [6:0] funct7 = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic       outValid, pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable;
    logic       pcAdderSrc, writeBackFromAluOrMemory, mulDivEnable, illegal, busy;
    logic [1:0] aluSrc1, aluSrc2;
    logic [2:0] aluOperation;
    logic [4:0] outRd;

    int errors = 0;
    int checks = 0;

    pipelined_control_unit #(.REG_ADDR_W(5), .MULDIV_LATENCY(LAT), .ENABLE_M(1'b1)) dut (
        .clk(clk), .resetN(resetN), .flush(flush), .inValid(inValid), .inReady(inReady),
        .opcode(opcode), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .outValid(outValid), .pcUpdate(pcUpdate), .memoryReadEnable(memoryReadEnable),
        .memoryWriteEnable(memoryWriteEnable), .registerWriteEnable(registerWriteEnable),
        .pcAdderSrc(pcAdderSrc), .writeBackFromAluOrMemory(writeBackFromAluOrMemory),
        .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .aluOperation(aluOperation),
        .mulDivEnable(mulDivEnable), .illegal(illegal), .outRd(outRd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Packed view: {outValid, pcUpd, memRd, memWr, regWr, pcAdderSrc, wbMem, src1, src2, aluOp, mulDiv, illegal, outRd}
    function automatic logic [20:0] dutVec();
        return {outValid, pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable,
                pcAdderSrc, writeBackFromAluOrMemory, aluSrc1, aluSrc2, aluOperation,
                mulDivEnable, illegal, outRd};
    endfunction

    function automatic logic [20:0] expWord(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] d);
        logic [14:0] c;
        logic        md;
        md = (op == 7'b0110011) && (f7 == 7'b0000001);
        case (op)
            7'b0110011: c = {6'b000100, 2'b00, 2'b00, 3'b010, md, 1'b0};
            7'b0010011: c = {6'b000100, 2'b00, 2'b01, 3'b011, 2'b00};
            7'b0000011: c = {6'b010101, 2'b00, 2'b01, 3'b000, 2'b00};
            7'b0100011: c = {6'b001000, 2'b00, 2'b01, 3'b000, 2'b00};
            7'b1100011: c = {6'b100000, 2'b00, 2'b00, 3'b001, 2'b00};
            7'b1101111: c = {6'b100100, 2'b01, 2'b10, 3'b100, 2'b00};
            7'b1100111: c = {6'b100110, 2'b01, 2'b10, 3'b101, 2'b00};
            7'b0110111: c = {6'b000100, 2'b10, 2'b01, 3'b110, 2'b00};
            7'b0010111: c = {6'b000100, 2'b01, 2'b01, 3'b111, 2'b00};
            default:    c = 15'b000000_00_00_000_0_1;
        endcase
        return {1'b1, c, d};
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic fl);
        inValid = v; opcode = op; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #12;
        checks++;
        if (dutVec() !== 21'd0) begin errors++; $display("FAIL reset_word got=%h exp=%h", dutVec(), 21'd0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        resetN = 1'b1;
        drive(1'b1, 7'b0110011, 7'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        tick();
        checks++;
        if (dutVec() !== expWord(7'b0110011, 7'd0, 5'd3))
            begin errors++; $display("FAIL first_accept got=%h exp=%h", dutVec(), expWord(7'b0110011, 7'd0, 5'd3)); end
    endtask

    task automatic test_opcode_sweep();
        logic [6:0] ops [10];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ops[i], 7'd0, 5'(i + 1), 5'd0, 5'd0, 1'b0);
            tick();
            checks++;
            if (dutVec() !== expWord(ops[i], 7'd0, 5'(i + 1)))
                begin errors++; $display("FAIL sweep_op%b got=%h exp=%h", ops[i], dutVec(), expWord(ops[i], 7'd0, 5'(i + 1))); end
        end
        checks++;
        if (illegal !== 1'b1 || outValid !== 1'b1)
            begin errors++; $display("FAIL sweep_illegal got ill=%b vld=%b exp 1/1", illegal, outValid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 7'b0000011, 7'd0, 5'd5, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 7'd0, 5'd6, 5'd5, 5'd2, 1'b0);
        #1;
        checks++;
        if (inReady !== 1'b0) begin errors++; $display("FAIL loaduse_stall got=%b exp=0", inReady); end
        tick();
        checks++;
        if (dutVec() !== 21'd0) begin errors++; $display("FAIL loaduse_bubble got=%h exp=0", dutVec()); end
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL loaduse_release got=%b exp=1", inReady); end
        tick();
        checks++;
        if (dutVec() !== expWord(7'b0110011, 7'd0, 5'd6))
            begin errors++; $display("FAIL loaduse_add got=%h exp=%h", dutVec(), expWord(7'b0110011, 7'd0, 5'd6)); end
        drive(1'b1, 7'b0000011, 7'd0, 5'd0, 5'd1, 5'd0, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 7'd0, 5'd6, 5'd0, 5'd0, 1'b0);
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL loaduse_x0_ready got=%b exp=1", inReady); end
        tick();
        checks++;
        if (dutVec() !== expWord(7'b0110011, 7'd0, 5'd6))
            begin errors++; $display("FAIL loaduse_x0_add got=%h exp=%h", dutVec(), expWord(7'b0110011, 7'd0, 5'd6)); end
    endtask

    task automatic test_muldiv();
        logic [20:0] expSeq [5];
        logic        busySeq [5];
        expSeq  = '{expWord(7'b0110011, 7'b0000001, 5'd7), 21'd0, 21'd0, 21'd0, expWord(7'b0110011, 7'd0, 5'd8)};
        busySeq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 7'b0110011, 7'b0000001, 5'd7, 5'd1, 5'd2, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 7'd0, 5'd8, 5'd1, 5'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dutVec() !== expSeq[k] || busy !== busySeq[k] || inReady !== !busySeq[k])
                begin errors++; $display("FAIL muldiv_cyc%0d got=%h busy=%b rdy=%b exp=%h busy=%b", k, dutVec(), busy, inReady, expSeq[k], busySeq[k]); end
            if (k < 4) tick();
        end
    endtask

    task automatic test_flush_wait();
        drive(1'b1, 7'b0110011, 7'b0000001, 5'd9, 5'd1, 5'd2, 1'b0);
        tick();
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flushwait_pre_busy got=%b exp=1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b1)
            begin errors++; $display("FAIL flushwait got busy=%b vld=%b rdy=%b exp 0/0/1", busy, outValid, inReady); end
    endtask

    task automatic test_flush_loaduse();
        drive(1'b1, 7'b0000011, 7'd0, 5'd9, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 7'b0110011, 7'd0, 5'd4, 5'd9, 5'd0, 1'b1);
        #1;
        checks++;
        if (inReady !== 1'b0) begin errors++; $display("FAIL flushlu_ready got=%b exp=0", inReady); end
        tick();
        checks++;
        if (dutVec() !== 21'd0) begin errors++; $display("FAIL flushlu_bubble got=%h exp=0", dutVec()); end
        flush = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1) begin errors++; $display("FAIL flushlu_nostall got=%b exp=1", inReady); end
        tick();
        checks++;
        if (dutVec() !== expWord(7'b0110011, 7'd0, 5'd4))
            begin errors++; $display("FAIL flushlu_add got=%h exp=%h", dutVec(), expWord(7'b0110011, 7'd0, 5'd4)); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 7'b0110011, 7'b0000001, 5'd10, 5'd1, 5'd2, 1'b0);
        tick();
        drive(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy got=%b exp=1", busy); end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dutVec() !== 21'd0)
            begin errors++; $display("FAIL areset got busy=%b word=%h exp 0/0", busy, dutVec()); end
        #2 resetN = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [20:0] mVec, nextVec;
        int          busyLeft;
        logic        hazard, expReady;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        mVec = 21'd0;
        busyLeft = 0;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)],
                  ($urandom_range(0, 2) == 0) ? 7'b0000001 : 7'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0));
            #1;
            hazard   = mVec[20] && mVec[18] && (mVec[4:0] != 5'd0) && inValid &&
                       ((mVec[4:0] == rs1) || (mVec[4:0] == rs2));
            expReady = (busyLeft == 0) && !hazard && !flush;
            checks++;
            if (inReady !== expReady)
                begin errors++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, inReady, expReady); end
            if (flush) begin
                nextVec = 21'd0;
                busyLeft = 0;
            end else if (inValid && expReady) begin
                nextVec = expWord(opcode, funct7, rd);
                busyLeft = nextVec[6] ? LAT - 1 : 0;
            end else begin
                nextVec = 21'd0;
                if (busyLeft > 0) busyLeft--;
            end
            mVec = nextVec;
            tick();
            checks++;
            if (dutVec() !== mVec || busy !== (busyLeft > 0))
                begin errors++; $display("FAIL rand_word n=%0d got=%h busy=%b exp=%h busy=%b", n, dutVec(), busy, mVec, busyLeft > 0); end
        end
    endtask

    initial begin
        test_reset();
        test_opcode_sweep();
        test_load_use();
        test_muldiv();
        test_flush_wait();
        test_flush_loaduse();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), resetN (asserted low, acts immediately, no clock required).
REQ-002 The block SHALL have these parameters (name, default, meaning):
- REG_ADDR_W, 5, register-index width.
- MULDIV_LATENCY, 4, EX occupancy in cycles of an M-extension op; legal range 1..15.
- ENABLE_M, 1, set to 1 to decode M-extension ops; set to 0 to treat them as plain R-type.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- resetN, in, 1, async active-low reset.
- flush, in, 1, squash the registered word and any pending multicycle wait.
- inValid, in, 1, decode-stage instruction present.
- inReady, out, 1, instruction accepted this cycle.
- opcode, in, 7, instruction opcode.
- funct7, in, 7, instruction funct7.
- rd, in, REG_ADDR_W, destination register.
- rs1, in, REG_ADDR_W, source register 1.
- rs2, in, REG_ADDR_W, source register 2.
- outValid, out, 1, registered control word valid.
- pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable, pcAdderSrc, writeBackFromAluOrMemory, out, 1 each, registered controls.
- aluSrc1, out, 2, registered control.
- aluSrc2, out, 2, registered control.
- aluOperation, out, 3, registered control.
- mulDivEnable, out, 1, registered word is an M-extension op.
- illegal, out, 1, registered word came from an unknown opcode.
- outRd, out, REG_ADDR_W, registered destination register.
- busy, out, 1, multicycle wait in progress.

Function
REQ-004 Decode table (regWr, memRd, memWr, pcUpd, aluSrc1, aluSrc2, aluOp, pcAdderSrc, wbMem); every field not listed is 0:
- 0110011 R: regWr, src 00/00, op 010.
- 0010011 I: regWr, src 00/01, op 011.
- 0000011 Load: regWr, memRd, wbMem, src 00/01, op 000.
- 0100011 Store: memWr, src 00/01, op 000.
- 1100011 Branch: pcUpd, src 00/00, op 001.
- 1101111 JAL: pcUpd, regWr, src 01/10, op 100.
- 1100111 JALR: pcUpd, regWr, src 01/10, op 101, pcAdderSrc=1.
- 0110111 LUI: regWr, src 10/01, op 110.
- 0010111 AUIPC: regWr, src 01/01, op 111.
REQ-005 Any other opcode SHALL produce an all-zero control word with illegal=1 and outValid=1.
REQ-006 An instruction with opcode 0110011, funct7=0000001 and ENABLE_M=1 SHALL decode as R-type with mulDivEnable=1.
REQ-007 Latency SHALL be one cycle: an instruction accepted at edge N appears on the outputs after edge N, with outValid=1.
REQ-008 inReady SHALL equal (state==RUN) AND NOT loadUse AND NOT flush.
REQ-009 When inValid=1 and inReady=0, the outputs SHALL load a bubble (outValid=0, all controls 0).
REQ-010 loadUse SHALL be asserted when all of the following hold: outValid=1, memoryReadEnable=1, outRd!=0, inValid=1, and outRd equals rs1 or rs2.
REQ-011 A load-use hazard SHALL insert exactly one bubble; the stalled instruction is accepted on the following cycle.
REQ-012 The FSM SHALL have two states, RUN and MULDIV_WAIT.
- Accepting an M-extension op with MULDIV_LATENCY>1 SHALL move the FSM to MULDIV_WAIT and load a 4-bit counter with MULDIV_LATENCY-1.
- In MULDIV_WAIT the counter SHALL decrement each cycle, and the FSM SHALL return to RUN on the cycle the counter reaches 0.
- With MULDIV_LATENCY=1 the FSM SHALL remain in RUN.
REQ-013 busy SHALL equal (state==MULDIV_WAIT), and bubbles SHALL be issued while busy=1.
REQ-014 A flush sampled high at an edge SHALL clear the output register to a bubble, force the FSM to RUN and zero the counter.
REQ-015 Flush SHALL take priority over acceptance, load-use and the counter.
REQ-016 When inValid=0, a bubble SHALL be registered.

Reset
REQ-017 While resetN=0 the block SHALL hold: outValid=0, all controls 0, illegal=0, mulDivEnable=0, outRd=0, busy=0, FSM=RUN, counter=0.
REQ-018 After resetN deasserts, the first rising edge SHALL accept an instruction if inValid=1.
REQ-019 Reset asserted mid-MULDIV_WAIT SHALL immediately return the block to the REQ-017 values.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Opcode sweep: each of the nine opcodes and 0000000, each with inValid=1 → next-cycle word matches REQ-004; 0000000 gives illegal=1, outValid=1.
- Load-use: LW x5 then ADD rs1=5 → inReady=0 for one cycle, one bubble, then ADD word; repeat with rd=0 → no stall.
- MUL with MULDIV_LATENCY=4 → MUL word for one cycle, then busy=1 and inReady=0 for 3 cycles, then RUN.
- Flush during MULDIV_WAIT, counter=2 → next cycle busy=0, outValid=0, inReady=1.
- Flush coincident with a load-use and inValid=1 → bubble registered, instruction not accepted, no stall carried over.
- Async reset pulse between clock edges while busy=1 → outputs and busy go 0 without a clock edge.
